divu: RTL
=========

// Module: divu
// PURPOSE
//  Multi-cycle unsigned restoring divider; inverse companion of the shift-add multiplier.
//  Start with doDiv: computes quotient = a / b, remainder = a % b in N iterations.
//  One shift-subtract per clock on a 2N-bit remainder/quotient register.
//  Sits beside the multiplier in the ALU datapath; same doX/X_done control style.
// PARAMETERS
//  N  32  operand width; quotient and remainder are N bits, the counter is $clog2(N)+1 bits
// PORTS
//  clk          in   1  system clock; all state changes on rising edge
//  reset        in   1  synchronous, active-low; sampled only on rising edge of clk
//  a            in   N  dividend, sampled on the start edge only
//  b            in   N  divisor, sampled on the start edge only
//  doDiv        in   1  start request, honoured only in IDLE
//  quotient     out  N  result quotient, held until next start
//  remainder    out  N  result remainder, held until next start
//  div_done     out  1  high for exactly one cycle (DONE state)
//  busy         out  1  high in RUN; low in IDLE and DONE
//  div_by_zero  out  1  set with div_done when b==0; held until next start
// BEHAVIOUR
//  Reset (reset==0 at an edge, any state): state=IDLE, internal regs=0,
//   quotient=0, remainder=0, div_done=0, busy=0, div_by_zero=0. Reset mid-operation aborts.
//   No div_done is issued for the aborted op.
//  State registers: divisor D (N bits), RQ (2N bits), cnt, state. FSM states are IDLE, RUN, DONE.
//  IDLE, doDiv==1 at edge (the start edge), b!=0: D<=b, RQ<={N'b0,a}, cnt<=0, clear div_by_zero.
//   Next state is RUN.
//  IDLE, doDiv==1 at edge, b==0: quotient<={N{1'b1}}, remainder<=a, div_by_zero<=1.
//   Next state is DONE. No RUN cycles occur.
//  IDLE, doDiv==0: stay.
//  RUN, each edge:
//   - S = {RQ[2N-2:0],1'b0}.
//   - T = {1'b0,S[2N-1:N]} - {1'b0,D}, computed in N+1 bits.
//   - If T[N]==0: RQ<={T[N-1:0],S[N-1:1],1'b1}. Else: RQ<=S.
//   - cnt<=cnt+1.
//   - When cnt==N-1 at the edge: next state DONE, remainder<=new RQ[2N-1:N], quotient<=new RQ[N-1:0].
//  DONE: div_done=1 for one cycle. Next edge goes to IDLE unconditionally.
//   doDiv during DONE is ignored and must be re-asserted in IDLE.
//  Latency: normal op has div_done high in the cycle after the (N+1)th edge counted from the start edge.
//   For N=32, div_done is high 33 cycles after start. For b==0, div_done is high the cycle after the start edge.
//  doDiv during RUN: ignored. Changes on a/b after the start edge do not affect the result.
//  Outputs quotient/remainder/div_by_zero are registered.
//   They change only at completion (transition into DONE) or at reset, and hold through IDLE.
//  busy and div_done are Moore decodes of state.
//  Throughput: back-to-back ops need doDiv in IDLE; minimum N+2 cycles per op.
// TESTING
//  1. a=100, b=7, doDiv 1 cycle -> busy 32 cycles, div_done 1 cycle at start+33, q=14, r=2, dbz=0
//  2. a=32'hFFFFFFFF, b=1 -> q=32'hFFFFFFFF, r=0. Then a=3, b=10 -> q=0, r=3. Check prior results held until 2nd done.
//  3. a=5, b=0 -> div_done high at start+1, q=32'hFFFFFFFF, r=5, dbz=1. Next op a=9, b=3 -> q=3, r=0, dbz=0.
//  4. a=32'h80000000, b=32'hFFFFFFFF -> q=0, r=32'h80000000. a=32'hFFFFFFFF, b=32'h80000000 -> q=1, r=32'h7FFFFFFF.
//  5. Start a=1000, b=3; pulse reset low at RUN cycle 10 -> all outputs 0, IDLE, no div_done.
//     Then a=1000, b=3 -> q=333, r=1.
//  6. Hold doDiv high continuously; change a/b every cycle during RUN.
//     Required: result matches operands from the start edge, a single div_done, and new op starts only from IDLE.
//     Period is 34 cycles.
//  Every test: compare against a/b and a%b reference model, and check div_done is exactly one cycle wide.

Source files
------------

// File: rtl/divu.sv
`default_nettype none
// ============================================================================
// Module      : divu
// Description : Multi-cycle unsigned restoring divider. A start request in
//               IDLE launches N shift-subtract steps on a 2N-bit combined
//               remainder/quotient register; the result is published on
//               entry to DONE, which lasts exactly one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module divu #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         doDiv,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_done,
  output logic         busy,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  localparam logic [CW-1:0] c_last_step = CW'(N - 1);

  logic [1:0]     r_state;
  logic [N-1:0]   r_d;
  logic [2*N-1:0] r_rq;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_quot;
  logic [N-1:0]   r_rem;
  logic           r_dbz;

  // Shifted partial remainder including the bit leaving the register. At
  // step k the partial remainder is below 2^k, so that top bit is always
  // zero and this equals the zero-extended upper half of the shifted value.
  logic [N:0]     w_top;
  logic [N:0]     w_t;
  logic [2*N-1:0] w_rq_next;

  // One restoring step: subtract if it fits, shifting in a quotient one.
  always_comb begin
    w_top     = r_rq[2*N-1:N-1];
    w_t       = w_top - {1'b0, r_d};
    w_rq_next = {r_rq[2*N-2:0], 1'b0};
    if (!w_t[N]) begin
      w_rq_next = {w_t[N-1:0], r_rq[N-2:0], 1'b1};
    end
  end

  // Control FSM, datapath registers and registered results.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= c_idle;
      r_d     <= '0;
      r_rq    <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (doDiv) begin
            if (b == '0) begin
              // Divide by zero completes immediately with all-ones quotient.
              r_quot  <= '1;
              r_rem   <= a;
              r_dbz   <= 1'b1;
              r_state <= c_done;
            end else begin
              r_d     <= b;
              r_rq    <= {{N{1'b0}}, a};
              r_cnt   <= '0;
              r_dbz   <= 1'b0;
              r_state <= c_run;
            end
          end
        end
        c_run: begin
          r_rq  <= w_rq_next;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == c_last_step) begin
            r_rem   <= w_rq_next[2*N-1:N];
            r_quot  <= w_rq_next[N-1:0];
            r_state <= c_done;
          end
        end
        c_done: begin
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  // Status outputs are pure decodes of the state register.
  always_comb begin
    busy     = (r_state == c_run);
    div_done = (r_state == c_done);
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire
